// File: rtl/com_pkg.sv
// Shared types and default widths for the centroid block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package com_pkg;

   localparam int H_WIDTH     = 11;
   localparam int V_WIDTH     = 10;
   localparam int COUNT_WIDTH = 20;
   localparam int SUM_WIDTH   = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } com_state_t;

endpackage

// File: rtl/divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Latency: loads on the start_in edge, done_out pulses WIDTH cycles later.
// Backpressure: none; a start_in while busy restarts the divide.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             done_out,
   output logic             busy_out
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    iter_q, iter_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH:0]   shifted;

   // One restoring step per cycle: shift in the next dividend bit, subtract
   // when it fits. A zero divisor always "fits", giving an all-ones quotient.
   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      if (start_in) begin
         rem_d  = '0;
         quo_d  = dividend_in;
         dvs_d  = divisor_in;
         iter_d = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         if (shifted >= {1'b0, dvs_q}) begin
            rem_d = shifted - {1'b0, dvs_q};
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted;
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
         iter_d = iter_q + 1'b1;
         if (iter_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // Divider state registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         iter_q <= iter_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign quotient_out  = quo_q;
   assign remainder_out = rem_q[WIDTH-1:0];
   assign done_out      = done_q;
   assign busy_out      = busy_q;

endmodule

// File: rtl/center_of_mass.sv
// Accumulates marked-pixel coordinates and divides by the count at frame end.
// Latency: valid_out pulses SUM_WIDTH+2 cycles after the tabulate_in cycle.
// Backpressure: none; tabulate_in while a divide is running is ignored.
module center_of_mass
   import com_pkg::*;
#(
   parameter int H_WIDTH     = com_pkg::H_WIDTH,
   parameter int V_WIDTH     = com_pkg::V_WIDTH,
   parameter int COUNT_WIDTH = com_pkg::COUNT_WIDTH,
   parameter int SUM_WIDTH   = com_pkg::SUM_WIDTH
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [H_WIDTH-1:0] x_in,
   input  logic [V_WIDTH-1:0] y_in,
   input  logic               valid_in,
   input  logic               tabulate_in,
   output logic [H_WIDTH-1:0] x_out,
   output logic [V_WIDTH-1:0] y_out,
   output logic               valid_out,
   output logic               busy_out
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

   com_state_t             state_q, state_d;
   logic [SUM_WIDTH-1:0]   x_sum_q, x_sum_d;
   logic [SUM_WIDTH-1:0]   y_sum_q, y_sum_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic [H_WIDTH-1:0]     x_out_q, x_out_d;
   logic [V_WIDTH-1:0]     y_out_q, y_out_d;
   logic                   valid_q, valid_d;
   logic                   busy_q, busy_d;

   // Live sums including this cycle's pixel; these are what a tabulate snapshots.
   logic [SUM_WIDTH-1:0]   x_acc, y_acc;
   logic [COUNT_WIDTH-1:0] count_acc;
   logic                   take, start;

   logic [SUM_WIDTH-1:0]   x_quo, y_quo, x_rem, y_rem;
   logic                   x_done, y_done, x_busy, y_busy;

   // Accumulate, snapshot on tabulate, and sequence IDLE -> DIVIDE -> DONE.
   always_comb begin
      x_acc     = x_sum_q;
      y_acc     = y_sum_q;
      count_acc = count_q;
      if (valid_in) begin
         x_acc = x_sum_q + {{(SUM_WIDTH-H_WIDTH){1'b0}}, x_in};
         y_acc = y_sum_q + {{(SUM_WIDTH-V_WIDTH){1'b0}}, y_in};
         if (count_q != COUNT_MAX) begin
            count_acc = count_q + 1'b1;
         end
      end

      take  = (state_q == IDLE) && tabulate_in;
      start = take && (count_acc != '0);

      x_sum_d = take ? '0 : x_acc;
      y_sum_d = take ? '0 : y_acc;
      count_d = take ? '0 : count_acc;

      state_d = state_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DIVIDE;
            end
         end
         DIVIDE: begin
            if (x_done) begin
               state_d = DONE;
               x_out_d = x_quo[H_WIDTH-1:0];
               y_out_d = y_quo[V_WIDTH-1:0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d  = (state_d == DIVIDE);
      valid_d = (state_d == DONE);
   end

   // All block state, synchronous reset.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         x_sum_q <= '0;
         y_sum_q <= '0;
         count_q <= '0;
         x_out_q <= '0;
         y_out_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_sum_q <= x_sum_d;
         y_sum_q <= y_sum_d;
         count_q <= count_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   // Both dividers share divisor and start, so they finish together; x's done
   // flag alone drives the FSM.
   divider #(.WIDTH(SUM_WIDTH)) u_div_x (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start),
      .dividend_in   (x_acc),
      .divisor_in    ({{(SUM_WIDTH-COUNT_WIDTH){1'b0}}, count_acc}),
      .quotient_out  (x_quo),
      .remainder_out (x_rem),
      .done_out      (x_done),
      .busy_out      (x_busy)
   );

   divider #(.WIDTH(SUM_WIDTH)) u_div_y (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start),
      .dividend_in   (y_acc),
      .divisor_in    ({{(SUM_WIDTH-COUNT_WIDTH){1'b0}}, count_acc}),
      .quotient_out  (y_quo),
      .remainder_out (y_rem),
      .done_out      (y_done),
      .busy_out      (y_busy)
   );

   // Quotient high bits are always zero (centroid lies inside the frame);
   // remainders and the divider status flags are not needed here.
   logic unused_bits;
   assign unused_bits = ^{x_quo[SUM_WIDTH-1:H_WIDTH], y_quo[SUM_WIDTH-1:V_WIDTH],
                          x_rem, y_rem, x_busy, y_busy, y_done};

   assign x_out     = x_out_q;
   assign y_out     = y_out_q;
   assign valid_out = valid_q;
   assign busy_out  = busy_q;

endmodule

// File: tb/tb_center_of_mass.sv
// Directed self-checking bench for center_of_mass.
// Latency: checks valid_out at tabulate cycle + 34.
// Backpressure: n/a.
module tb_center_of_mass;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] x_in;
   logic [9:0]  y_in;
   logic        valid_in;
   logic        tabulate_in;
   logic [10:0] x_out;
   logic [9:0]  y_out;
   logic        valid_out;
   logic        busy_out;

   int errors = 0;
   int checks = 0;

   center_of_mass dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .x_in        (x_in),
      .y_in        (y_in),
      .valid_in    (valid_in),
      .tabulate_in (tabulate_in),
      .x_out       (x_out),
      .y_out       (y_out),
      .valid_out   (valid_out),
      .busy_out    (busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send_px(input int x, input int y);
      valid_in = 1'b1;
      x_in     = 11'(x);
      y_in     = 10'(y);
      tick();
      valid_in = 1'b0;
   endtask

   task automatic pulse_tab();
      tabulate_in = 1'b1;
      tick();
      tabulate_in = 1'b0;
   endtask

   // Ticks until valid_out is seen; n = -1 if it never arrives within 100 cycles.
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (valid_out) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1; valid_in = 1'b0; tabulate_in = 1'b0; x_in = '0; y_in = '0;
      tick(); tick();
      rst_in = 1'b0;
      checks++;
      if ({x_out, y_out, valid_out, busy_out} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs: got x=%0d y=%0d v=%b b=%b, want all 0",
                  x_out, y_out, valid_out, busy_out);
      end
   endtask

   task automatic test_single_pixel();
      int n;
      send_px(100, 50);
      pulse_tab();
      checks++;
      if (busy_out !== 1'b1) begin
         errors++; $display("FAIL single_busy_t1: got %b, want 1", busy_out);
      end
      wait_valid(n);
      checks++;
      if (n + 1 !== 34) begin
         errors++; $display("FAIL single_latency: got %0d, want 34 (-1=timeout)", n + 1);
      end
      checks++;
      if (x_out !== 11'd100 || y_out !== 10'd50) begin
         errors++; $display("FAIL single_xy: got (%0d,%0d), want (100,50)", x_out, y_out);
      end
      checks++;
      if (busy_out !== 1'b0) begin
         errors++; $display("FAIL single_busy_done: got %b, want 0", busy_out);
      end
      tick();
      checks++;
      if (valid_out !== 1'b0) begin
         errors++; $display("FAIL single_pulse_width: valid_out got %b, want 0", valid_out);
      end
   endtask

   task automatic test_four_pixels();
      int n;
      send_px(10, 10);
      send_px(20, 10);
      send_px(10, 21);
      send_px(21, 21);
      pulse_tab();
      wait_valid(n);
      checks++;
      if (n !== 33 || x_out !== 11'd15 || y_out !== 10'd15) begin
         errors++;
         $display("FAIL four_px: got n=%0d (%0d,%0d), want n=33 (15,15)", n, x_out, y_out);
      end
   endtask

   task automatic test_empty_frame();
      int seen = 0;
      pulse_tab();
      for (int i = 0; i < 100; i++) begin
         if (valid_out || busy_out) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL empty_no_result: got %0d active cycles, want 0", seen);
      end
      checks++;
      if (x_out !== 11'd15 || y_out !== 10'd15) begin
         errors++; $display("FAIL empty_hold: got (%0d,%0d), want (15,15)", x_out, y_out);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int extra = 0;
      send_px(10, 20);
      valid_in = 1'b1; x_in = 11'd30; y_in = 10'd40; tabulate_in = 1'b1;
      tick();
      valid_in = 1'b0; tabulate_in = 1'b0;
      tick(); tick();
      send_px(5, 5);
      tick(); tick();
      pulse_tab();
      wait_valid(n);
      checks++;
      if (n !== 27 || x_out !== 11'd20 || y_out !== 10'd30) begin
         errors++;
         $display("FAIL same_cycle_px: got n=%0d (%0d,%0d), want n=27 (20,30)", n, x_out, y_out);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_out) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++; $display("FAIL busy_tab_ignored: got %0d extra pulses, want 0", extra);
      end
      pulse_tab();
      wait_valid(n);
      checks++;
      if (n !== 33 || x_out !== 11'd5 || y_out !== 10'd5) begin
         errors++;
         $display("FAIL px_during_divide: got n=%0d (%0d,%0d), want n=33 (5,5)", n, x_out, y_out);
      end
   endtask

   // 80x45 grid at x=16k+15, y=16j+15 spanning the whole 1280x720 frame.
   task automatic test_large_frame();
      int n;
      for (int j = 0; j < 45; j++) begin
         for (int k = 0; k < 80; k++) begin
            send_px(16 * k + 15, 16 * j + 15);
         end
      end
      pulse_tab();
      wait_valid(n);
      checks++;
      if (n !== 33 || x_out !== 11'd647 || y_out !== 10'd367) begin
         errors++;
         $display("FAIL large_frame: got n=%0d (%0d,%0d), want n=33 (647,367)", n, x_out, y_out);
      end
   endtask

   task automatic test_reset_mid_divide();
      int n;
      int seen = 0;
      send_px(7, 9);
      pulse_tab();
      tick(); tick(); tick();
      send_px(1000, 600);
      tick(); tick(); tick(); tick();
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      checks++;
      if ({x_out, y_out, valid_out, busy_out} !== 23'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got x=%0d y=%0d v=%b b=%b, want all 0",
                  x_out, y_out, valid_out, busy_out);
      end
      for (int i = 0; i < 60; i++) begin
         tick();
         if (valid_out || busy_out) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL mid_reset_abort: got %0d active cycles, want 0", seen);
      end
      send_px(3, 4);
      send_px(5, 8);
      pulse_tab();
      wait_valid(n);
      checks++;
      if (n !== 33 || x_out !== 11'd4 || y_out !== 10'd6) begin
         errors++;
         $display("FAIL after_reset_frame: got n=%0d (%0d,%0d), want n=33 (4,6)", n, x_out, y_out);
      end
   endtask

   initial begin
      test_reset();
      test_single_pixel();
      test_four_pixels();
      test_empty_frame();
      test_back_to_back();
      test_large_frame();
      test_reset_mid_divide();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
